sync_fifo_module: RTL and testbench
===================================

# sync_fifo_module

Single-clock, parametrised FIFO for buffering data between producer and consumer logic that share one clock domain. It offers the same write/read handshake and full/empty flags as the team's dual-clock FIFO, and adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- a selectable first-word-fall-through (FWFT) read mode;
- sticky overflow and underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_SIZE, 4, log2 of depth; DEPTH = 2**ADDR_SIZE
- AFULL_THRESH, 12, almost_full asserts when count >= this; legal range 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this; legal range 0..DEPTH-1
- FWFT, 0, read mode select: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  asynchronous, active-low reset
- wrt_data  input  DATA_WIDTH  write word
- wrt_ena  input  1  write request
- rd_ena  input  1  read request (pop)
- clr_err  input  1  synchronous clear of overflow and underflow
- rd_data  output  DATA_WIDTH  read word
- wrt_full  output  1  count == DEPTH
- rd_empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_THRESH
- almost_empty  output  1  count <= AEMPTY_THRESH
- fill_count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- underflow  output  1  sticky: a read was attempted while empty

## Operation
- **Write acceptance:** a write is accepted iff wrt_ena && !wrt_full. The word is stored at wrt_addr and wrt_addr increments.
- **Read acceptance:** a read is accepted iff rd_ena && !rd_empty. rd_addr increments.
- **Address wrap:** wrt_addr and rd_addr are ADDR_SIZE bits wide and wrap DEPTH-1 -> 0 naturally.
- **Count update:** fill_count is a register.
  - +1 on a write alone.
  - -1 on a read alone.
  - Unchanged on both or neither.
- **Flag derivation:** all four status flags are combinational decodes of the registered fill_count, so they are glitch-free and change only after a clock edge.
- **Simultaneous write and read:**
  - When full, the read is accepted, the write is rejected and overflow is set; count becomes DEPTH-1.
  - When empty, the write is accepted, the read is rejected and underflow is set; count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- **FWFT=0 (standard read):** rd_data is a register loaded with mem[rd_addr] on the edge that accepts a read. It holds its value at all other times.
- **FWFT=1 (first-word-fall-through):**
  - rd_data continuously presents mem[rd_addr] whenever rd_empty is low.
  - rd_ena acknowledges (pops) the presented word.
  - While rd_empty is high, rd_data is don't-care.
- **Error flags:**
  - overflow sets on any cycle with wrt_ena && wrt_full.
  - underflow sets on any cycle with rd_ena && rd_empty.
  - Both are cleared by clr_err. If a new error and clr_err occur in the same cycle, set wins.
- **Storage contents:** memory contents are neither reset nor cleared; rejected writes do not modify storage.
- **Parameter checks:** illegal threshold values must be flagged at elaboration (simulation $error); they need not be synthesisable checks.

## Timing
- **Reset values (rst low, asynchronous):**
  - fill_count = 0, pointers = 0, rd_data = 0.
  - rd_empty = 1, wrt_full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
- **Reset release:** rst deassertion is synchronous to clk; the first write may be presented in the first cycle after release.
- **Reset mid-operation:** all contents are logically discarded and the FIFO returns to empty immediately, without waiting for a clock edge.
- **Write latency:** a word written on edge N makes rd_empty deassert after edge N. It is readable from cycle N+1.
- **Read latency, FWFT=0:** rd_ena sampled at edge N -> rd_data valid after edge N (1 cycle).
- **Read latency, FWFT=1:** the head word is valid together with !rd_empty, with zero cycles of latency. After a pop at edge N, the next word is presented after edge N.
- **Flag timing:** every flag and fill_count reflects the transfers of the previous edge. There is no look-ahead, so a producer must react to wrt_full within 0 cycles or accept the overflow.
- **Throughput:** one write and one read per cycle are sustainable indefinitely at any occupancy 1..DEPTH-1.

## Test plan
- **Reset, then fill:** reset, then 16 writes 0x00..0x0F (defaults).
  - fill_count steps 1..16.
  - almost_empty drops after the write that makes count 5.
  - almost_full rises at count 12.
  - wrt_full rises after the 16th write.
  - overflow stays 0.
- **Overflow at full:** write 0xAA while full -> overflow=1, storage unchanged. Pulse clr_err -> overflow=0.
- **Drain, FWFT=0:** drain 16 reads.
  - rd_data sequence 0x00..0x0F, each valid 1 cycle after its rd_ena.
  - rd_empty rises after the 16th read.
  - A further rd_ena sets underflow=1, and rd_data holds 0x0F.
- **Wrap-around with simultaneous traffic:** preload 8 words, then 40 cycles of simultaneous wrt_ena/rd_ena with an incrementing pattern -> fill_count stays 8 and the data order is preserved across pointer wrap.
- **FWFT=1:** write 0x5A into an empty FIFO -> rd_empty=0 and rd_data=0x5A in the next cycle, with no rd_ena needed. Pop -> rd_empty=1.
- **Reset mid-operation:** assert rst mid-stream at count 7, between clock edges -> fill_count=0 and rd_empty=1 immediately. After release, the first write/read returns the new data only.

Source files
------------

// File: rtl/sync_fifo_module.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, optional first-word-fall-through read and sticky error flags.
module sync_fifo_module #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter bit          FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  input  logic                  wrt_ena,
  input  logic                  rd_ena,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wrt_full,
  output logic                  rd_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  // Threshold sanity checks, reported at elaboration.
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_afull_chk
    $error("sync_fifo_module: AFULL_THRESH %0d outside 1..%0d", AFULL_THRESH, DEPTH);
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_aempty_chk
    $error("sync_fifo_module: AEMPTY_THRESH %0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE-1:0]  wrt_addr_q, wrt_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full_c, empty_c, wr_acc_c, rd_acc_c;

  assign full_c   = (count_q == CW'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign wr_acc_c = wrt_ena && !full_c;
  assign rd_acc_c = rd_ena && !empty_c;

  // Next-state for pointers, occupancy and sticky errors (set beats clear).
  always_comb begin
    wrt_addr_d = wrt_addr_q;
    rd_addr_d  = rd_addr_q;
    count_d    = count_q;
    ovf_d      = (ovf_q && !clr_err) || (wrt_ena && full_c);
    unf_d      = (unf_q && !clr_err) || (rd_ena && empty_c);
    if (wr_acc_c) wrt_addr_d = wrt_addr_q + ADDR_SIZE'(1);
    if (rd_acc_c) rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrt_addr_q <= '0;
      rd_addr_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wrt_addr_q <= wrt_addr_d;
      rd_addr_q  <= rd_addr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is never reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wrt_addr_q] <= wrt_data;
  end

  if (FWFT) begin : g_fwft
    // Head word presented directly; forced to zero while empty.
    assign rd_data = empty_c ? '0 : mem_q[rd_addr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          rd_data_q <= '0;
      else if (rd_acc_c) rd_data_q <= mem_q[rd_addr_q];
    end
    assign rd_data = rd_data_q;
  end

  assign fill_count   = count_q;
  assign wrt_full     = full_c;
  assign rd_empty     = empty_c;
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_module.sv
// Bench for sync_fifo_module: standard and FWFT instances share one stimulus
// stream; a reference queue model scores data, occupancy and flags.
module tb_sync_fifo_module;

  localparam int unsigned DW    = 8;
  localparam int unsigned AS    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wrt_data = '0;
  logic          wrt_ena = 1'b0;
  logic          rd_ena = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          wrt_full0, wrt_full1, rd_empty0, rd_empty1;
  logic          afull0, afull1, aempty0, aempty1;
  logic [AS:0]   fill0, fill1;
  logic          ovf0, ovf1, unf0, unf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_module #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .AFULL_THRESH(12),
                     .AEMPTY_THRESH(4), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wrt_data(wrt_data), .wrt_ena(wrt_ena),
    .rd_ena(rd_ena), .clr_err(clr_err), .rd_data(rd_data0),
    .wrt_full(wrt_full0), .rd_empty(rd_empty0), .almost_full(afull0),
    .almost_empty(aempty0), .fill_count(fill0), .overflow(ovf0),
    .underflow(unf0));

  sync_fifo_module #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .AFULL_THRESH(12),
                     .AEMPTY_THRESH(4), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wrt_data(wrt_data), .wrt_ena(wrt_ena),
    .rd_ena(rd_ena), .clr_err(clr_err), .rd_data(rd_data1),
    .wrt_full(wrt_full1), .rd_empty(rd_empty1), .almost_full(afull1),
    .almost_empty(aempty1), .fill_count(fill1), .overflow(ovf1),
    .underflow(unf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected words are queued on accepted writes.
  logic [DW-1:0] sb_q[$];
  int            mcount = 0;
  logic [DW-1:0] exp_rd0 = '0;
  bit            movf = 1'b0, munf = 1'b0, wok, rok;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q.delete();
      mcount  = 0;
      exp_rd0 = '0;
      movf    = 1'b0;
      munf    = 1'b0;
    end else begin
      wok = wrt_ena && (mcount < DEPTH);
      rok = rd_ena && (mcount > 0);
      if (clr_err) begin movf = 1'b0; munf = 1'b0; end
      if (wrt_ena && mcount == DEPTH) movf = 1'b1;
      if (rd_ena && mcount == 0) munf = 1'b1;
      if (rok) exp_rd0 = sb_q.pop_front();
      if (wok) sb_q.push_back(wrt_data);
      mcount = sb_q.size();
    end
  end

  // Monitor: compares both instances against the model every cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("m_count0", 32'(fill0), 32'(mcount));
      chk("m_count1", 32'(fill1), 32'(mcount));
      chk("m_empty0", 32'(rd_empty0), 32'(mcount == 0));
      chk("m_full0", 32'(wrt_full0), 32'(mcount == DEPTH));
      chk("m_afull0", 32'(afull0), 32'(mcount >= 12));
      chk("m_aempty0", 32'(aempty0), 32'(mcount <= 4));
      chk("m_empty1", 32'(rd_empty1), 32'(mcount == 0));
      chk("m_full1", 32'(wrt_full1), 32'(mcount == DEPTH));
      chk("m_ovf0", 32'(ovf0), 32'(movf));
      chk("m_unf0", 32'(unf0), 32'(munf));
      chk("m_ovf1", 32'(ovf1), 32'(movf));
      chk("m_unf1", 32'(unf1), 32'(munf));
      chk("m_rd_data0", 32'(rd_data0), 32'(exp_rd0));
      if (mcount > 0) chk("m_rd_data1", 32'(rd_data1), 32'(sb_q[0]));
    end
  end

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit ce);
    wrt_ena  = we;
    wrt_data = wd;
    rd_ena   = re;
    clr_err  = ce;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(fill0), 0);
    chk("rst_empty", 32'(rd_empty0), 1);
    chk("rst_full", 32'(wrt_full0), 0);
    chk("rst_aempty", 32'(aempty0), 1);
    chk("rst_afull", 32'(afull0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_unf", 32'(unf0), 0);
    chk("rst_rd_data", 32'(rd_data0), 0);
    rst = 1'b1;
    @(negedge clk);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(fill0), 32'(i + 1));
      chk("fill_aempty", 32'(aempty0), 32'((i + 1) <= 4));
      chk("fill_afull", 32'(afull0), 32'((i + 1) >= 12));
      chk("fill_full", 32'(wrt_full0), 32'(i == 15));
      chk("fill_ovf", 32'(ovf0), 0);
    end

    // Write while full, then clear.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_count", 32'(fill0), 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf0), 0);

    // Drain in order; storage must be untouched by the rejected write.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(rd_data0), 32'(i));
      chk("drain_count", 32'(fill0), 32'(15 - i));
    end
    chk("drain_empty", 32'(rd_empty0), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(unf0), 1);
    chk("unf_hold", 32'(rd_data0), 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", 32'(unf0), 0);

    // Simultaneous write/read while empty: write only, underflow set.
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("sim_empty_count", 32'(fill0), 1);
    chk("sim_empty_unf", 32'(unf0), 1);
    chk("sim_empty_hold", 32'(rd_data0), 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, DW'(8'h34 + i), 1'b0, 1'b0);
    chk("sim_full_pre", 32'(wrt_full0), 1);

    // Simultaneous write/read while full: read only, overflow set.
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("sim_full_count", 32'(fill0), 15);
    chk("sim_full_ovf", 32'(ovf0), 1);
    chk("sim_full_data", 32'(rd_data0), 32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sim_full_drain", 32'(rd_data0), 32'(8'h34 + i));
    end
    chk("sim_full_empty", 32'(rd_empty0), 1);

    // Preload 8, then 40 cycles of concurrent traffic across pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(8'h48 + i), 1'b1, 1'b0);
      chk("wrap_data", 32'(rd_data0), 32'(8'h40 + i));
      chk("wrap_count", 32'(fill0), 8);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_drain", 32'(rd_data0), 32'(8'h68 + i));
    end
    chk("wrap_empty", 32'(rd_empty0), 1);

    // FWFT: head word visible without a read.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft_empty", 32'(rd_empty1), 0);
    chk("fwft_data", 32'(rd_data1), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(rd_empty1), 1);
    chk("fwft_std_data", 32'(rd_data0), 32'h5A);

    // Asynchronous reset mid-stream at count 7.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_pre_count", 32'(fill0), 7);
    #2 rst = 1'b0;
    #1;
    chk("mid_count0", 32'(fill0), 0);
    chk("mid_empty0", 32'(rd_empty0), 1);
    chk("mid_count1", 32'(fill1), 0);
    chk("mid_empty1", 32'(rd_empty1), 1);
    chk("mid_rd_data0", 32'(rd_data0), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("post_count", 32'(fill0), 1);
    chk("post_fwft_data", 32'(rd_data1), 32'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_std_data", 32'(rd_data0), 32'hC3);
    chk("post_empty", 32'(rd_empty0), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
